alu_rr_arbiter: RTL

//  Shares the single combinational ALU among NUM_REQ requesters (e.g. core

---
 rtl/alu_rr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one combinational ALU among NUM_REQ requesters.
// It has an issue register feeding the ALU and one held response register per requester.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_rd_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_rs_i,
    input  logic [NUM_REQ*OP_W-1:0]     req_op_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [DATA_W-1:0]           alu_rd_o,
    output logic [DATA_W-1:0]           alu_rs_o,
    output logic [OP_W-1:0]             alu_op_o,
    input  logic [DATA_W-1:0]           alu_result_i,
    input  logic                        alu_jump_i,
    output logic [NUM_REQ-1:0]          resp_valid_o,
    output logic [NUM_REQ*DATA_W-1:0]   resp_result_o,
    output logic [NUM_REQ-1:0]          resp_jump_o,
    input  logic [NUM_REQ-1:0]          resp_ready_i
);

    localparam int                PTR_W   = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]  PTR_RST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]    NREQ_W  = (PTR_W + 1)'(NUM_REQ);

    // Handshakes: a request transfers on a cycle where req_valid_i[k] & req_ready_o[k];
    // a response transfers where resp_valid_o[k] & resp_ready_i[k]. Ready never depends
    // on the matching valid being stable beyond that cycle.

    logic [NUM_REQ-1:0]         r_busy;
    logic [PTR_W-1:0]           r_ptr;
    logic                       r_iss_valid;
    logic [PTR_W-1:0]           r_iss_id;
    logic [DATA_W-1:0]          r_iss_rd;
    logic [DATA_W-1:0]          r_iss_rs;
    logic [OP_W-1:0]            r_iss_op;
    logic [NUM_REQ-1:0]         r_resp_valid;
    logic [NUM_REQ*DATA_W-1:0]  r_resp_result;
    logic [NUM_REQ-1:0]         r_resp_jump;

    logic [NUM_REQ-1:0]         w_eligible;
    logic [NUM_REQ-1:0]         w_grant;
    logic [PTR_W-1:0]           w_grant_idx;
    logic [PTR_W:0]             w_idx;
    logic                       w_found;
    logic                       w_accept;
    logic [DATA_W-1:0]          w_sel_rd;
    logic [DATA_W-1:0]          w_sel_rs;
    logic [OP_W-1:0]            w_sel_op;

    assign w_eligible = req_valid_i & ~r_busy;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = r_ptr;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            if (!w_found && w_eligible[w_idx[PTR_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx[PTR_W-1:0];
            end
        end
        if (w_found && !reset) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_accept = |w_grant;

    always_comb begin
        w_sel_rd = '0;
        w_sel_rs = '0;
        w_sel_op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_rd = req_rd_i[k*DATA_W +: DATA_W];
                w_sel_rs = req_rs_i[k*DATA_W +: DATA_W];
                w_sel_op = req_op_i[k*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy        <= '0;
            r_ptr         <= PTR_RST;
            r_iss_valid   <= 1'b0;
            r_iss_id      <= '0;
            r_iss_rd      <= '0;
            r_iss_rs      <= '0;
            r_iss_op      <= '0;
            r_resp_valid  <= '0;
            r_resp_result <= '0;
            r_resp_jump   <= '0;
        end else begin
            r_iss_valid <= w_accept;
            if (w_accept) begin
                r_iss_id <= w_grant_idx;
                r_iss_rd <= w_sel_rd;
                r_iss_rs <= w_sel_rs;
                r_iss_op <= w_sel_op;
                r_ptr    <= w_grant_idx;
            end
            // Grant needs ~busy and consume needs busy, so the two never hit the same k.
            for (int k = 0; k < NUM_REQ; k++) begin
                if (r_resp_valid[k] && resp_ready_i[k]) begin
                    r_resp_valid[k] <= 1'b0;
                    r_busy[k]       <= 1'b0;
                end
                if (w_grant[k]) begin
                    r_busy[k] <= 1'b1;
                end
                if (r_iss_valid && (r_iss_id == PTR_W'(k))) begin
                    r_resp_valid[k]                    <= 1'b1;
                    r_resp_result[k*DATA_W +: DATA_W] <= alu_result_i;
                    r_resp_jump[k]                     <= alu_jump_i;
                end
            end
        end
    end

    assign req_ready_o   = w_grant;
    assign alu_rd_o      = r_iss_rd;
    assign alu_rs_o      = r_iss_rs;
    assign alu_op_o      = r_iss_op;
    assign resp_valid_o  = r_resp_valid;
    assign resp_result_o = r_resp_result;
    assign resp_jump_o   = r_resp_jump;

endmodule
